edge_event_arbiter: RTL and testbench

Multi-channel rising-edge event collector and round-robin arbiter. Each of N_CH level inputs gets its own rising-edge detector and a one-deep pending flag. Pending events are granted one per cycle to a single shared consumer over a valid/ready handshake. A saturating counter tracks events lost because a channel's pending flag was already set.

---
 rtl/edge_event_arbiter.sv | 71 +++++++
 tb/tb_edge_event_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising-edge capture with one-deep pending flags,
// round-robin grant into a single valid/ready slot, and a saturating drop counter.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  localparam int ID_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  go,
  output logic             ev_valid,
  output logic [ID_W-1:0]  ev_id,
  input  logic             ev_ready,
  output logic [N_CH-1:0]  pending,
  output logic [CNT_W-1:0] drop_cnt,
  input  logic             clr_drop
);
  localparam int SW = CNT_W + ID_W + 1;
  logic [N_CH-1:0] go_q, rise, grant_vec, drop;
  logic [ID_W-1:0] last, win;
  logic [ID_W:0] n_drop;
  logic [SW-1:0] sum;
  logic [CNT_W-1:0] sat;
  logic found, load;
  int idx;
  assign rise = go & ~go_q;
  assign load = !ev_valid || ev_ready;
  // search starts just after the last winner and wraps
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(last) + k) % N_CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win = ID_W'(idx);
      end
    end
  end
  always_comb begin
    grant_vec = '0;
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) grant_vec[i] = load && found && (win == ID_W'(i));
    drop = rise & pending & ~grant_vec;
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + (ID_W+1)'(drop[i]);
    sum = SW'(drop_cnt) + SW'(n_drop);
    sat = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q <= '0;
      pending <= '0;
      ev_valid <= 1'b0;
      ev_id <= '0;
      last <= ID_W'(N_CH-1);
      drop_cnt <= '0;
    end else begin
      go_q <= go;
      pending <= (pending & ~grant_vec) | rise;
      drop_cnt <= clr_drop ? '0 : sat;
      if (load) begin
        ev_valid <= found;
        if (found) begin
          ev_id <= win;
          last <= win;
        end
      end
    end
  end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vectors for edge capture, round-robin order,
// backpressure, drop saturation, held levels and asynchronous reset.
module tb_edge_event_arbiter;
  logic clk = 0, rst_n = 0, ev_ready = 1, clr_drop = 0, ev_valid;
  logic [3:0] go = '0, pending;
  logic [1:0] ev_id;
  logic [7:0] drop_cnt;
  int n_chk = 0, n_fail = 0, n_ev;

  edge_event_arbiter #(.N_CH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .ev_valid(ev_valid), .ev_id(ev_id),
    .ev_ready(ev_ready), .pending(pending), .drop_cnt(drop_cnt), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input logic [3:0] g);
    rst_n = 0;
    go = g;
    clr_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", ev_valid, 0);
    check("rst_id", ev_id, 0);
    check("rst_pending", pending, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1;
    // single rise, two edges to ev_valid
    @(negedge clk);
    go = 4'b0100;
    @(negedge clk);
    check("t1_pend", pending, 4'b0100);
    check("t1_nvalid", ev_valid, 0);
    @(negedge clk);
    check("t1_valid", ev_valid, 1);
    check("t1_id", ev_id, 2);
    check("t1_pend0", pending, 0);
    @(negedge clk);
    check("t1_done", ev_valid, 0);
    check("t1_drop", drop_cnt, 0);
    // all four at once, round robin from channel 0
    do_reset(4'b0000);
    ev_ready = 1;
    go = 4'b1111;
    @(negedge clk);
    check("t2_pend", pending, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t2_valid", ev_valid, 1);
      check("t2_id", ev_id, k);
    end
    @(negedge clk);
    check("t2_idle", ev_valid, 0);
    check("t2_pend0", pending, 0);
    // backpressure
    do_reset(4'b0000);
    ev_ready = 0;
    go = 4'b0010;
    repeat (2) @(negedge clk);
    check("t3_slot", ev_id, 1);
    go = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t3_hold_v", ev_valid, 1);
      check("t3_hold_id", ev_id, 1);
      check("t3_hold_p", pending, 4'b1000);
    end
    ev_ready = 1;
    @(negedge clk);
    check("t3_next_v", ev_valid, 1);
    check("t3_next_id", ev_id, 3);
    check("t3_next_p", pending, 0);
    @(negedge clk);
    check("t3_idle", ev_valid, 0);
    // drops, clear, clear priority, saturation
    do_reset(4'b0000);
    ev_ready = 0;
    go = 4'b0001;
    @(negedge clk);
    go = 4'b0000;
    @(negedge clk);
    check("t4_slot", ev_id, 0);
    check("t4_slot_v", ev_valid, 1);
    go = 4'b0001;
    @(negedge clk);
    check("t4_pend", pending, 4'b0001);
    check("t4_nodrop", drop_cnt, 0);
    go = 4'b0000;
    @(negedge clk);
    go = 4'b0001;
    @(negedge clk);
    check("t4_drop1", drop_cnt, 1);
    go = 4'b0000;
    clr_drop = 1;
    @(negedge clk);
    check("t4_clr", drop_cnt, 0);
    go = 4'b0001;
    @(negedge clk);
    check("t4_clr_wins", drop_cnt, 0);
    go = 4'b0000;
    clr_drop = 0;
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      go = 4'b0001;
      @(negedge clk);
      go = 4'b0000;
      @(negedge clk);
    end
    check("t4_sat", drop_cnt, 255);
    // held level gives one event
    do_reset(4'b0000);
    ev_ready = 1;
    go = 4'b0100;
    n_ev = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ev_valid) begin
        n_ev++;
        check("t5_id", ev_id, 2);
      end
    end
    check("t5_count", n_ev, 1);
    do_reset(4'b0001);
    n_ev = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ev_valid) begin
        n_ev++;
        check("t5r_id", ev_id, 0);
      end
    end
    check("t5r_count", n_ev, 1);
    // asynchronous reset mid-cycle with slot full, pending and drops
    do_reset(4'b0000);
    ev_ready = 0;
    go = 4'b0001;
    repeat (2) @(negedge clk);
    go = 4'b0111;
    @(negedge clk);
    check("t6_pend", pending, 4'b0110);
    go = 4'b0001;
    @(negedge clk);
    go = 4'b0111;
    @(negedge clk);
    check("t6_drop", drop_cnt, 2);
    check("t6_valid", ev_valid, 1);
    @(posedge clk);
    #2 rst_n = 0;
    go = 4'b0000;
    #1;
    check("t6_async_v", ev_valid, 0);
    check("t6_async_p", pending, 0);
    check("t6_async_d", drop_cnt, 0);
    @(negedge clk);
    rst_n = 1;
    n_ev = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ev_valid) n_ev++;
    end
    check("t6_quiet", n_ev, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
